// File: rtl/adc_serial_ctrl_if.sv
// Host-side handshake of the ADC serial controller: conversion request,
// channel select, status and the registered result.
interface adc_serial_ctrl_if #(
  parameter int DATA_W = 12
);
  logic              START;
  logic [2:0]        CHAN;
  logic              BUSY;
  logic              DONE;
  logic [DATA_W-1:0] DATA;
  logic [2:0]        DATA_CH;

  modport master (
    output START, CHAN,
    input  BUSY, DONE, DATA, DATA_CH
  );

  modport slave (
    input  START, CHAN,
    output BUSY, DONE, DATA, DATA_CH
  );
endinterface

// File: rtl/adc_serial_ctrl.sv
// Serial ADC conversion controller.
// A START in IDLE latches a channel, waits CONV_TICKS TICK pulses with the
// chip deselected, then clocks 2*DATA_W TICK half-periods of SCLK. It shifts
// a 6-bit config word {1, ch, 1, 0} out on ADC_DIN and DATA_W result bits in
// from ADC_DOUT, and presents the result with a one-cycle DONE strobe.
// All converter pins come straight from flops.
// Optional build macro: ADC_AUTOSCAN_EN. When it is defined, CHAN is ignored
// and an internal counter steps through channels 0..NUM_CH-1, advancing once
// per completed conversion.
module adc_serial_ctrl #(
  parameter int DATA_W     = 12,
  parameter int CONV_TICKS = 4,
  parameter int NUM_CH     = 8
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            TICK,
  adc_serial_ctrl_if.slave host,
  output logic            ADC_CS_n,
  output logic            ADC_SCLK,
  output logic            ADC_DIN,
  input  logic            ADC_DOUT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    XFER = 2'd2,
    FIN  = 2'd3
  } state_t;

  // One counter serves both the conversion wait and the transfer index k.
  localparam int CNT_MAX = (CONV_TICKS > 2*DATA_W) ? CONV_TICKS : 2*DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_TICKS - 1);
  localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(2*DATA_W - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [2:0]        ch, ch_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic              busy_nx, done_nx, cs_n_nx, sclk_nx, din_nx;
  logic [DATA_W-1:0] data_nx;
  logic [2:0]        data_ch_nx;
  logic              conv_end, xfer_end;
`ifdef ADC_AUTOSCAN_EN
  logic [2:0]        scan, scan_nx;
`endif

  // Out-of-range channel requests fold back into 0..NUM_CH-1.
  function automatic logic [2:0] wrap_chan(input logic [2:0] c);
    return 3'(int'(c) % NUM_CH);
  endfunction

  // Bit idx (0 = first sent) of the config word; zero once the word is out.
  function automatic logic cfg_bit(input logic [2:0] c, input int idx);
    logic [5:0] w;
    w = {1'b1, c, 2'b10};
    if (idx > 5) return 1'b0;
    return w[3'(5 - idx)];
  endfunction

  assign conv_end = TICK && (cnt == CONV_LAST);
  assign xfer_end = TICK && (cnt == XFER_LAST);

  // State register; reset returns to IDLE and aborts any transaction.
  always_ff @(posedge CLK) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: only leaving IDLE ignores TICK; FIN always lasts one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (host.START) state_nx = CONV;
      CONV:    if (conv_end)   state_nx = XFER;
      XFER:    if (xfer_end)   state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of all registered outputs, counters and the shift register.
  always_comb begin
    cnt_nx     = cnt;
    ch_nx      = ch;
    shreg_nx   = shreg;
    busy_nx    = host.BUSY;
    done_nx    = 1'b0;
    cs_n_nx    = ADC_CS_n;
    sclk_nx    = ADC_SCLK;
    din_nx     = ADC_DIN;
    data_nx    = host.DATA;
    data_ch_nx = host.DATA_CH;
`ifdef ADC_AUTOSCAN_EN
    scan_nx    = scan;
`endif
    case (state)
      IDLE: begin
        if (host.START) begin
          cnt_nx  = '0;
`ifdef ADC_AUTOSCAN_EN
          ch_nx   = scan;
`else
          ch_nx   = wrap_chan(host.CHAN);
`endif
          busy_nx = 1'b1;
          cs_n_nx = 1'b1;
          sclk_nx = 1'b0;
          din_nx  = 1'b0;
        end
      end
      CONV: begin
        if (conv_end) begin
          // Select the chip and present the first config bit together.
          cnt_nx  = '0;
          cs_n_nx = 1'b0;
          din_nx  = cfg_bit(ch, 0);
        end else if (TICK) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      XFER: begin
        if (TICK) begin
          cnt_nx = cnt + 1'b1;
          if (!cnt[0]) begin
            // Even k: rising SCLK, sample the converter on this same edge.
            sclk_nx  = 1'b1;
            shreg_nx = {shreg[DATA_W-2:0], ADC_DOUT};
          end else begin
            // Odd k: falling SCLK, advance the config bit.
            sclk_nx = 1'b0;
            din_nx  = cfg_bit(ch, (int'(cnt) + 1) / 2);
          end
          if (xfer_end) begin
            // Last sample was taken at k = 2*DATA_W-2, so shreg is complete.
            cnt_nx     = '0;
            cs_n_nx    = 1'b1;
            sclk_nx    = 1'b0;
            din_nx     = 1'b0;
            done_nx    = 1'b1;
            data_nx    = shreg;
            data_ch_nx = ch;
          end
        end
      end
      FIN: begin
        busy_nx = 1'b0;
`ifdef ADC_AUTOSCAN_EN
        scan_nx = (int'(scan) >= NUM_CH - 1) ? 3'd0 : scan + 3'd1;
`endif
      end
      default: begin
        busy_nx = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset takes priority over START and TICK.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      cnt          <= '0;
      ch           <= '0;
      host.BUSY    <= 1'b0;
      host.DONE    <= 1'b0;
      host.DATA    <= '0;
      host.DATA_CH <= '0;
      ADC_CS_n     <= 1'b1;
      ADC_SCLK     <= 1'b0;
      ADC_DIN      <= 1'b0;
`ifdef ADC_AUTOSCAN_EN
      scan         <= '0;
`endif
    end else begin
      cnt          <= cnt_nx;
      ch           <= ch_nx;
      host.BUSY    <= busy_nx;
      host.DONE    <= done_nx;
      host.DATA    <= data_nx;
      host.DATA_CH <= data_ch_nx;
      ADC_CS_n     <= cs_n_nx;
      ADC_SCLK     <= sclk_nx;
      ADC_DIN      <= din_nx;
`ifdef ADC_AUTOSCAN_EN
      scan         <= scan_nx;
`endif
    end
  end

  // Receive shift register; a partial word is simply overwritten next time.
  always_ff @(posedge CLK) begin
    shreg <= shreg_nx;
  end

endmodule
